// File: rtl/axi_lite_csr_slave.sv
// axi_lite_csr_slave: AXI4-Lite CSR bank with control/status registers, packet counter and W1C interrupts
module axi_lite_csr_slave #(
  parameter int          ADDR_W  = 8,
  parameter logic [31:0] VERSION = 32'h0001_0000,
  parameter int          NUM_EVT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  s_axi_awaddr,
  input  logic               s_axi_awvalid,
  output logic               s_axi_awready,
  input  logic [31:0]        s_axi_wdata,
  input  logic [3:0]         s_axi_wstrb,
  input  logic               s_axi_wvalid,
  output logic               s_axi_wready,
  output logic [1:0]         s_axi_bresp,
  output logic               s_axi_bvalid,
  input  logic               s_axi_bready,
  input  logic [ADDR_W-1:0]  s_axi_araddr,
  input  logic               s_axi_arvalid,
  output logic               s_axi_arready,
  output logic [31:0]        s_axi_rdata,
  output logic [1:0]         s_axi_rresp,
  output logic               s_axi_rvalid,
  input  logic               s_axi_rready,
  input  logic [31:0]        status_i,
  input  logic               rx_pkt_i,
  input  logic [NUM_EVT-1:0] event_i,
  output logic [31:0]        ctrl_o,
  output logic               irq_o
);
  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;
  w_state_t ws;
  r_state_t rs;
  logic [31:0] scratch, cnt, mask, rd;
  logic [NUM_EVT-1:0] irq_st, irq_en, clr;
  logic [6:0] wsel, rsel;
  logic we, unused;
  assign unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  assign we = ws == W_ACK;
  always_comb begin
    wsel = '0;
    rsel = '0;
    for (int i = 0; i < 7; i++) begin
      wsel[i] = s_axi_awaddr[ADDR_W-1:2] == (ADDR_W-2)'(i);
      rsel[i] = s_axi_araddr[ADDR_W-1:2] == (ADDR_W-2)'(i);
    end
    mask = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}}, {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};
    clr = we && wsel[4] ? s_axi_wdata[NUM_EVT-1:0] & mask[NUM_EVT-1:0] : '0;
    rd = ({32{rsel[0]}} & ctrl_o) | ({32{rsel[1]}} & status_i) | ({32{rsel[2]}} & scratch) |
         ({32{rsel[3]}} & cnt) | ({32{rsel[4]}} & 32'(irq_st)) | ({32{rsel[5]}} & 32'(irq_en)) |
         ({32{rsel[6]}} & VERSION);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_o  <= '0;
      scratch <= '0;
      cnt     <= '0;
      irq_st  <= '0;
      irq_en  <= '0;
      irq_o   <= 1'b0;
    end else begin
      if (we && wsel[0]) ctrl_o <= (ctrl_o & ~mask) | (s_axi_wdata & mask);
      if (we && wsel[2]) scratch <= (scratch & ~mask) | (s_axi_wdata & mask);
      if (we && wsel[5]) irq_en <= (irq_en & ~mask[NUM_EVT-1:0]) | (s_axi_wdata[NUM_EVT-1:0] & mask[NUM_EVT-1:0]);
      if (we && wsel[3]) cnt <= 32'(rx_pkt_i);
      else if (rx_pkt_i && cnt != '1) cnt <= cnt + 32'd1;
      irq_st <= (irq_st & ~clr) | event_i;
      irq_o  <= |(irq_st & irq_en);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws            <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 2'b00;
    end else begin
      case (ws)
        W_IDLE: if (s_axi_awvalid && s_axi_wvalid) begin
          s_axi_awready <= 1'b1;
          s_axi_wready  <= 1'b1;
          ws            <= W_ACK;
        end
        W_ACK: begin
          s_axi_awready <= 1'b0;
          s_axi_wready  <= 1'b0;
          s_axi_bvalid  <= 1'b1;
          s_axi_bresp   <= |wsel ? 2'b00 : 2'b10;
          ws            <= W_RESP;
        end
        W_RESP: if (s_axi_bready) begin
          s_axi_bvalid <= 1'b0;
          ws           <= W_IDLE;
        end
        default: ws <= W_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs            <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= 2'b00;
    end else begin
      case (rs)
        R_IDLE: if (s_axi_arvalid) begin
          s_axi_arready <= 1'b1;
          rs            <= R_ACK;
        end
        R_ACK: begin
          s_axi_arready <= 1'b0;
          s_axi_rvalid  <= 1'b1;
          s_axi_rdata   <= rd;
          s_axi_rresp   <= |rsel ? 2'b00 : 2'b10;
          rs            <= R_DATA;
        end
        R_DATA: if (s_axi_rready) begin
          s_axi_rvalid <= 1'b0;
          rs           <= R_IDLE;
        end
        default: rs <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_csr_slave.sv
// tb_axi_lite_csr_slave: directed and randomized AXI-Lite traffic against a register-map reference model
module tb_axi_lite_csr_slave;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_bready = 0, s_axi_arvalid = 0, s_axi_rready = 0;
  logic [31:0] s_axi_wdata = '0, status_i = 32'hDEAD_BEEF;
  logic [3:0] s_axi_wstrb = '0;
  logic rx_pkt_i = 0;
  logic [7:0] event_i = '0;
  logic s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, irq_o;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata, ctrl_o;
  int total = 0, bad = 0, hs = 0, split = 0;
  logic [31:0] m_ctrl = '0, m_scr = '0, m_cnt = '0;
  logic [7:0] m_ist = '0, m_ien = '0;

  axi_lite_csr_slave dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .status_i(status_i),
    .rx_pkt_i(rx_pkt_i), .event_i(event_i), .ctrl_o(ctrl_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (s_axi_awready && s_axi_wready) hs++;
    if (s_axi_awready != s_axi_wready) split++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = old;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic void m_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                                  input logic rx, input logic [7:0] ev);
    logic [31:0] clrm = merge(32'h0, d, s);
    if (a[7:2] == 3) m_cnt = 32'(rx);
    else if (rx && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    case (a[7:2])
      0: m_ctrl = merge(m_ctrl, d, s);
      2: m_scr = merge(m_scr, d, s);
      4: m_ist = m_ist & ~clrm[7:0];
      5: m_ien = merge({24'h0, m_ien}, d, s) & 32'hFF;
      default: ;
    endcase
    m_ist = m_ist | ev;
  endfunction

  function automatic logic [33:0] m_read(input logic [7:0] a);
    case (a[7:2])
      0: return {2'b00, m_ctrl};
      1: return {2'b00, status_i};
      2: return {2'b00, m_scr};
      3: return {2'b00, m_cnt};
      4: return {2'b00, 24'h0, m_ist};
      5: return {2'b00, 24'h0, m_ien};
      6: return {2'b00, 32'h0001_0000};
      default: return {2'b10, 32'h0};
    endcase
  endfunction

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic rx, input logic [7:0] ev, output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s; s_axi_awvalid = 1; s_axi_wvalid = 1;
    while (!s_axi_awready && n < 16) begin @(negedge clk); n++; end
    chk("aw_wait", {31'b0, s_axi_awready}, 32'd1);
    rx_pkt_i = rx; event_i = ev;
    @(negedge clk);
    rx_pkt_i = 0; event_i = '0; s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 1;
    n = 0;
    while (!s_axi_bvalid && n < 16) begin @(negedge clk); n++; end
    chk("b_wait", {31'b0, s_axi_bvalid}, 32'd1);
    resp = s_axi_bresp;
    @(negedge clk);
    s_axi_bready = 0;
    m_write(a, d, s, rx, ev);
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    s_axi_araddr = a; s_axi_arvalid = 1;
    while (!s_axi_arready && n < 16) begin @(negedge clk); n++; end
    chk("ar_wait", {31'b0, s_axi_arready}, 32'd1);
    @(negedge clk);
    s_axi_arvalid = 0; s_axi_rready = 1;
    n = 0;
    while (!s_axi_rvalid && n < 16) begin @(negedge clk); n++; end
    chk("r_wait", {31'b0, s_axi_rvalid}, 32'd1);
    d = s_axi_rdata; resp = s_axi_rresp;
    @(negedge clk);
    s_axi_rready = 0;
  endtask

  task automatic check_read(input string tag, input logic [7:0] a);
    logic [31:0] d;
    logic [1:0] r;
    logic [33:0] e = m_read(a);
    axi_read(a, d, r);
    chk({tag, "_data"}, d, e[31:0]);
    chk({tag, "_resp"}, 32'(r), 32'(e[33:32]));
  endtask

  task automatic pulse_rx();
    @(negedge clk); rx_pkt_i = 1;
    @(negedge clk); rx_pkt_i = 0;
    if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
  endtask

  initial begin
    logic [1:0] resp;
    logic [31:0] d;
    logic [7:0] a;
    int h0, n;
    repeat (2) @(negedge clk);
    chk("rst_awready", {31'b0, s_axi_awready}, 0);
    chk("rst_wready", {31'b0, s_axi_wready}, 0);
    chk("rst_bvalid", {31'b0, s_axi_bvalid}, 0);
    chk("rst_arready", {31'b0, s_axi_arready}, 0);
    chk("rst_rvalid", {31'b0, s_axi_rvalid}, 0);
    chk("rst_resps", {28'b0, s_axi_bresp, s_axi_rresp}, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_ctrl", ctrl_o, 0);
    chk("rst_irq", {31'b0, irq_o}, 0);
    rst = 0;
    h0 = hs;
    axi_write(8'h00, 32'hA5A5_0001, 4'hF, 0, 0, resp);
    chk("ctrl_bresp", 32'(resp), 0);
    chk("ctrl_hs_once", hs - h0, 1);
    chk("ctrl_ctrl_o", ctrl_o, 32'hA5A5_0001);
    check_read("ctrl_rd", 8'h00);
    axi_write(8'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, resp);
    axi_write(8'h08, 32'h1234_5678, 4'b0101, 0, 0, resp);
    chk("scr_model", m_scr, 32'hFF34_FF78);
    check_read("scr_strb", 8'h08);
    repeat (5) pulse_rx();
    check_read("cnt5", 8'h0C);
    axi_write(8'h0C, 32'h0, 4'hF, 1, 0, resp);
    chk("cnt_clr_bresp", 32'(resp), 0);
    check_read("cnt_clr_rx", 8'h0C);
    axi_write(8'h14, 32'h1, 4'hF, 0, 0, resp);
    @(negedge clk); event_i = 8'h03;
    @(negedge clk); event_i = 8'h00; m_ist |= 8'h03;
    chk("irq_lag", {31'b0, irq_o}, 0);
    @(negedge clk);
    chk("irq_set", {31'b0, irq_o}, {31'b0, |(m_ist & m_ien)});
    check_read("ist3", 8'h10);
    axi_write(8'h10, 32'h1, 4'hF, 0, 0, resp);
    check_read("ist_w1c", 8'h10);
    chk("irq_clr", {31'b0, irq_o}, {31'b0, |(m_ist & m_ien)});
    axi_write(8'h10, 32'h2, 4'hF, 0, 8'h02, resp);
    check_read("ist_setwins", 8'h10);
    check_read("version", 8'h18);
    check_read("unmapped_rd", 8'h3C);
    axi_write(8'h3C, 32'hFFFF_FFFF, 4'hF, 0, 0, resp);
    chk("unmapped_bresp", 32'(resp), 32'h2);
    for (int i = 0; i < 7; i++) check_read("post_unmapped", 8'(4 * i));
    for (int i = 0; i < 40; i++) begin
      n = int'($urandom_range(2));
      a = (n == 0 ? 8'h00 : n == 1 ? 8'h08 : 8'h14) | 8'($urandom_range(3));
      status_i = $urandom;
      axi_write(a, $urandom, 4'($urandom_range(15)), 1'($urandom_range(1)), 8'h0, resp);
      chk("rnd_bresp", 32'(resp), 0);
      check_read("rnd_rd", 8'(4 * $urandom_range(7)));
    end
    h0 = hs;
    @(negedge clk);
    s_axi_awaddr = 8'h08; s_axi_wdata = 32'hCAFE_F00D; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1; s_axi_wvalid = 1;
    n = 0;
    while (!s_axi_awready && n < 16) begin @(negedge clk); n++; end
    chk("hold_aw_wait", {31'b0, s_axi_awready}, 1);
    @(negedge clk);
    s_axi_wdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_bvalid", {31'b0, s_axi_bvalid}, 1);
      chk("hold_no_accept", {30'b0, s_axi_awready, s_axi_wready}, 0);
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 1;
    @(negedge clk); s_axi_bready = 0;
    m_write(8'h08, 32'hCAFE_F00D, 4'hF, 0, 0);
    chk("hold_hs_once", hs - h0, 1);
    chk("aw_w_together", split, 0);
    check_read("hold_scr", 8'h08);
    @(negedge clk);
    s_axi_araddr = 8'h08; s_axi_arvalid = 1;
    n = 0;
    while (!s_axi_arready && n < 16) begin @(negedge clk); n++; end
    chk("rstrd_ar_wait", {31'b0, s_axi_arready}, 1);
    rst = 1;
    #1;
    chk("rstrd_arready", {31'b0, s_axi_arready}, 0);
    chk("rstrd_rvalid", {31'b0, s_axi_rvalid}, 0);
    s_axi_arvalid = 0;
    @(negedge clk);
    chk("rstrd_rvalid_hold", {31'b0, s_axi_rvalid}, 0);
    chk("rstrd_ctrl", ctrl_o, 0);
    rst = 0;
    m_ctrl = '0; m_scr = '0; m_cnt = '0; m_ist = '0; m_ien = '0;
    check_read("after_rst_scr", 8'h08);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_lite_csr_slave.md
Name: axi_lite_csr_slave

Overview:
- AXI4-Lite slave register bank that terminates the AXI-Lite control bus driven by the PS/testbench master.
- Exposes dataplane control (CTRL, SCRATCH, IRQ_EN), status (STATUS, VERSION), a receive-packet counter and a W1C interrupt register.
- Drives irq_o to the PS.
- Sits directly downstream of the AXI-Lite master; its register outputs feed the dataplane.

Parameters:
- ADDR_W, 8, AXI address width; bits [ADDR_W-1:2] decode word registers, bits [1:0] ignored.
- VERSION, 32'h0001_0000, constant returned by VERSION register.
- NUM_EVT, 8, width of event_i and IRQ registers (1..32).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_axi_awaddr  in  ADDR_W  write address.
- s_axi_awvalid in 1 / s_axi_awready out 1  write address handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte enables.
- s_axi_wvalid in 1 / s_axi_wready out 1  write data handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid out 1 / s_axi_bready in 1  write response handshake.
- s_axi_araddr  in  ADDR_W  read address.
- s_axi_arvalid in 1 / s_axi_arready out 1  read address handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid out 1 / s_axi_rready in 1  read data handshake.
- status_i  in  32  live dataplane status.
- rx_pkt_i  in  1  one-cycle pulse per received packet.
- event_i  in  NUM_EVT  one-cycle event pulses.
- ctrl_o  out  32  CTRL register.
- irq_o  out  1  registered: |(IRQ_STATUS & IRQ_EN).

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While rst is high, all registers and outputs are 0: all READY/VALID, bresp, rresp, rdata, ctrl_o, irq_o, SCRATCH, IRQ_EN, IRQ_STATUS and RX_PKT_CNT.
- Register map (byte offset):
  - 0x00 CTRL: RW.
  - 0x04 STATUS: RO, value = status_i.
  - 0x08 SCRATCH: RW.
  - 0x0C RX_PKT_CNT: RO; any write clears it.
  - 0x10 IRQ_STATUS: W1C.
  - 0x14 IRQ_EN: RW, low NUM_EVT bits.
  - 0x18 VERSION: RO.
- Write channel FSM, states W_IDLE, W_ACK, W_RESP:
  - W_IDLE: wait until awvalid and wvalid are both high.
  - W_ACK: awready and wready are high together for exactly one cycle; the register update takes effect at that edge.
  - W_RESP: bvalid is high from the next cycle and held until bready is sampled high; then return to W_IDLE.
  - If only one of awvalid/wvalid is high, nothing is accepted. No new write is accepted while bvalid is high.
- WSTRB: byte k of an RW register is updated only if wstrb[k] is set. For W1C, only bits in enabled bytes clear.
- Write responses:
  - Mapped address: bresp = 2'b00, including writes to RO registers, which are ignored (RX_PKT_CNT excepted: cleared).
  - Unmapped address: bresp = 2'b10 (SLVERR), no state change.
- Read channel FSM, states R_IDLE, R_ACK, R_DATA:
  - On arvalid, arready pulses for one cycle.
  - rdata and rresp are captured at that edge.
  - rvalid rises the next cycle and is held, with rdata stable, until rready is sampled high.
  - Unmapped address: rdata = 0, rresp = 2'b10.
- Channel independence: read and write channels run concurrently and independently. A read of a register being written in the same handshake cycle returns the pre-write value.
- RX_PKT_CNT:
  - Increments on rx_pkt_i and saturates at 32'hFFFF_FFFF.
  - A clear-write and an rx_pkt_i in the same cycle give the value 1.
- IRQ_STATUS:
  - Bit set by event_i[n].
  - An event and a W1C on the same bit in the same cycle leave the bit set (set wins).
- irq_o: registered, so it lags IRQ_STATUS/IRQ_EN changes by one cycle.
- Reset mid-transaction: FSMs return to idle and any pending response is dropped; the master must reissue.

Test Plan:
- Write 0x00 = 0xA5A5_0001, wstrb 4'hF -> awready and wready pulse together once; bvalid asserted with bresp 0; ctrl_o = 0xA5A5_0001; read 0x00 returns the same value, rresp 0.
- Write SCRATCH 0xFFFF_FFFF, then write 0x1234_5678 with wstrb 4'b0101 -> read 0x08 = 0xFF34_FF78.
- Pulse rx_pkt_i 5 times -> read 0x0C = 5. Write 0x0C with an rx_pkt_i pulse in the same handshake cycle -> read 0x0C = 1.
- IRQ_EN = 0x01, event_i = 0x03 for one cycle:
  - IRQ_STATUS = 0x03 and irq_o = 1 one cycle later.
  - W1C 0x01 -> IRQ_STATUS = 0x02, irq_o = 0.
  - W1C 0x02 coinciding with event_i[1] -> bit 1 stays set.
- Read 0x18 -> 0x0001_0000. Read 0x3C -> rdata 0, rresp 2'b10. Write 0x3C -> bresp 2'b10, no register changes.
- Hold bready low 10 cycles -> bvalid held, second write not accepted. Assert rst mid-read -> rvalid and arready drop to 0 immediately.
